// File: rtl/cmp_unit_seq.sv
// Multi-cycle set-on-compare unit: computes a - b CHUNK bits per cycle through
// one narrow adder and reports SLT / SLTU / EQ / SGE as a WIDTH-wide 0/1 result.
module cmp_unit_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $fatal(1, "cmp_unit_seq: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             flag_q, flag_d;

  logic [WIDTH-1:0] a_shift, b_shift;
  logic [CHUNK:0]   sum;
  logic             zero_now, lt_s, lt_u, flag_now;

  // Operands are consumed LSB chunk first by shifting the latched copies down;
  // the sign bits are kept separately for the final signed decision.
  generate
    if (CHUNK < WIDTH) begin : g_shift
      assign a_shift = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
      assign b_shift = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
    end else begin : g_noshift
      assign a_shift = '0;
      assign b_shift = '0;
    end
  endgenerate

  always_comb begin
    sum      = {1'b0, a_q[CHUNK-1:0]} + {1'b0, ~b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    zero_now = zero_q & (sum[CHUNK-1:0] == '0);
    // Differing signs decide directly; otherwise the difference cannot overflow.
    lt_s     = (sa_q != sb_q) ? sa_q : sum[CHUNK-1];
    lt_u     = ~sum[CHUNK];
    case (mode_q)
      2'b00:   flag_now = lt_s;
      2'b01:   flag_now = lt_u;
      2'b10:   flag_now = zero_now;
      default: flag_now = ~lt_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
          mode_d  = mode;
          cnt_d   = '0;
          carry_d = 1'b1;
          zero_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_shift;
        b_d     = b_shift;
        carry_d = sum[CHUNK];
        zero_d  = zero_now;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          flag_d  = flag_now;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      flag_q  <= flag_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = {{(WIDTH-1){1'b0}}, flag_q};

endmodule
